result_pager: RTL and testbench

- Display-side stage directly downstream of the matrix multiplier.
- On each new result strobe, captures the four result words into a shadow register.
- Pages through them one 4-bit nibble at a time; the four selected nibbles feed the four seven-segment decoders.
- Pages advance on a synchronized push-button or on an automatic timer, so results wider than one hex digit can be read out in full.

---
 rtl/result_pager.sv | 131 +++++++++++++
 tb/tb_result_pager.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/result_pager.sv
// ============================================================================
// Module   : result_pager
// Brief    : Captures four result words on a result strobe and pages through
//            them one nibble at a time for four seven-segment decoders.
// Revision : 1.0
// ============================================================================
`default_nettype none

module result_pager #(
  parameter int RES_W    = 16,
  parameter int NIB      = RES_W / 4,
  parameter int TICK_DIV = 25000000,
  localparam int PAGE_W  = (NIB > 1) ? $clog2(NIB) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              res_valid,
  input  logic [RES_W-1:0]  res0,
  input  logic [RES_W-1:0]  res1,
  input  logic [RES_W-1:0]  res2,
  input  logic [RES_W-1:0]  res3,
  input  logic              next_btn,
  input  logic              auto_en,
  output logic [3:0]        nib0,
  output logic [3:0]        nib1,
  output logic [3:0]        nib2,
  output logic [3:0]        nib3,
  output logic [PAGE_W-1:0] page,
  output logic              blank,
  output logic              fresh,
  output logic              wrap
);

  localparam int CNT_W = $clog2(TICK_DIV);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    SHOW  = 1'b1
  } state_t;

  state_t            r_state;
  logic [RES_W-1:0]  r_shadow [4];
  logic [PAGE_W-1:0] r_page;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_res_d;
  logic              r_s1;
  logic              r_s2;
  logic              r_s3;
  logic              r_blank;
  logic              r_fresh;
  logic              r_wrap;

  logic              w_cap;
  logic              w_man;
  logic              w_auto;
  logic              w_adv;
  logic              w_last;
  logic [3:0]        w_nib [4];

  assign w_cap  = res_valid & ~r_res_d;
  assign w_man  = r_s2 & ~r_s3;
  assign w_auto = (r_state == SHOW) && auto_en && (r_cnt == CNT_W'(TICK_DIV - 1));
  assign w_adv  = (w_man | w_auto) && (r_state == SHOW);
  assign w_last = (r_page == PAGE_W'(NIB - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= EMPTY;
      r_shadow <= '{default: '0};
      r_page   <= '0;
      r_cnt    <= '0;
      r_res_d  <= 1'b0;
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_s3     <= 1'b0;
      r_blank  <= 1'b1;
      r_fresh  <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      r_res_d <= res_valid;
      r_s1    <= next_btn;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_wrap  <= 1'b0;
      // A capture overrides any advance in the same cycle.
      if (w_cap) begin
        r_shadow[0] <= res0;
        r_shadow[1] <= res1;
        r_shadow[2] <= res2;
        r_shadow[3] <= res3;
        r_page      <= '0;
        r_fresh     <= 1'b1;
        r_state     <= SHOW;
        r_blank     <= 1'b0;
        r_cnt       <= '0;
      end else if (r_state == SHOW) begin
        if (w_adv) begin
          r_page  <= w_last ? '0 : r_page + PAGE_W'(1);
          r_wrap  <= w_last;
          r_fresh <= 1'b0;
          r_cnt   <= '0;
        end else if (auto_en) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end else begin
          r_cnt <= '0;
        end
      end
    end
  end

  always_comb begin
    for (int w = 0; w < 4; w++) begin
      w_nib[w] = 4'h0;
      for (int p = 0; p < NIB; p++) begin
        if (r_page == PAGE_W'(p)) w_nib[w] = r_shadow[w][p*4 +: 4];
      end
    end
  end

  assign nib0  = w_nib[0];
  assign nib1  = w_nib[1];
  assign nib2  = w_nib[2];
  assign nib3  = w_nib[3];
  assign page  = r_page;
  assign blank = r_blank;
  assign fresh = r_fresh;
  assign wrap  = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_result_pager.sv
// ============================================================================
// Module   : tb_result_pager
// Brief    : Directed self-checking bench for result_pager (RES_W=16, TICK_DIV=4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_result_pager;

  logic        clk;
  logic        rst;
  logic        res_valid;
  logic [15:0] res0, res1, res2, res3;
  logic        next_btn;
  logic        auto_en;
  logic [3:0]  nib0, nib1, nib2, nib3;
  logic [1:0]  page;
  logic        blank, fresh, wrap;

  int total;
  int bad;

  result_pager #(
    .RES_W    (16),
    .NIB      (4),
    .TICK_DIV (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .res_valid (res_valid),
    .res0      (res0),
    .res1      (res1),
    .res2      (res2),
    .res3      (res3),
    .next_btn  (next_btn),
    .auto_en   (auto_en),
    .nib0      (nib0),
    .nib1      (nib1),
    .nib2      (nib2),
    .nib3      (nib3),
    .page      (page),
    .blank     (blank),
    .fresh     (fresh),
    .wrap      (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Button pressed right after an edge; page changes on the third edge.
  task automatic press_btn();
    next_btn = 1'b1;
    repeat (3) tick();
    next_btn = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_idle(input string tag);
    repeat (10) tick();
    total++;
    if (blank !== 1'b1) begin bad++; $display("FAIL %s_blank got=%b want=1", tag, blank); end
    total++;
    if ({nib0, nib1, nib2, nib3} !== 16'h0000) begin
      bad++; $display("FAIL %s_nibs got=%h want=0000", tag, {nib0, nib1, nib2, nib3});
    end
    total++;
    if ({page, fresh, wrap} !== 4'b0000) begin
      bad++; $display("FAIL %s_page_fresh_wrap got=%b want=0000", tag, {page, fresh, wrap});
    end
    press_btn();
    total++;
    if (page !== 2'd0) begin bad++; $display("FAIL %s_btn_in_empty page got=%0d want=0", tag, page); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    test_idle("reset");
  endtask

  task automatic test_capture();
    res0 = 16'h1234; res1 = 16'hABCD; res2 = 16'h0F0F; res3 = 16'h8001;
    res_valid = 1'b1;
    tick();
    total++;
    if ({nib0, nib1, nib2, nib3} !== 16'h4DF1) begin
      bad++; $display("FAIL capture_nibs got=%h want=4df1", {nib0, nib1, nib2, nib3});
    end
    total++;
    if ({page, blank, fresh} !== 4'b0001) begin
      bad++; $display("FAIL capture_flags got=%b want=0001", {page, blank, fresh});
    end
    // Changed data while res_valid stays high must not be taken.
    res0 = 16'hFFFF; res1 = 16'hFFFF; res2 = 16'hFFFF; res3 = 16'hFFFF;
    repeat (20) tick();
    total++;
    if ({nib0, nib1, nib2, nib3} !== 16'h4DF1) begin
      bad++; $display("FAIL capture_once got=%h want=4df1", {nib0, nib1, nib2, nib3});
    end
    res_valid = 1'b0;
    tick();
  endtask

  task automatic test_manual();
    logic [15:0] exp_nibs [4];
    exp_nibs[0] = 16'h3C00;
    exp_nibs[1] = 16'h2BF0;
    exp_nibs[2] = 16'h1A08;
    exp_nibs[3] = 16'h4DF1;
    auto_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      next_btn = 1'b1;
      tick();
      tick();
      total++;
      if (page !== 2'(i)) begin bad++; $display("FAIL manual_early page got=%0d want=%0d", page, i); end
      tick();
      total++;
      if (page !== 2'((i + 1) % 4)) begin
        bad++; $display("FAIL manual_page got=%0d want=%0d", page, (i + 1) % 4);
      end
      total++;
      if ({nib0, nib1, nib2, nib3} !== exp_nibs[i]) begin
        bad++; $display("FAIL manual_nibs got=%h want=%h", {nib0, nib1, nib2, nib3}, exp_nibs[i]);
      end
      total++;
      if (wrap !== (i == 3)) begin bad++; $display("FAIL manual_wrap got=%b want=%b", wrap, (i == 3)); end
      if (i == 0) begin
        total++;
        if (fresh !== 1'b0) begin bad++; $display("FAIL manual_fresh got=%b want=0", fresh); end
      end
      next_btn = 1'b0;
      tick();
      if (i == 3) begin
        total++;
        if (wrap !== 1'b0) begin bad++; $display("FAIL manual_wrap_pulse got=%b want=0", wrap); end
      end
      repeat (3) tick();
    end
  endtask

  task automatic test_auto();
    auto_en = 1'b1;
    repeat (3) tick();
    total++;
    if (page !== 2'd0) begin bad++; $display("FAIL auto_early page got=%0d want=0", page); end
    tick();
    total++;
    if (page !== 2'd1) begin bad++; $display("FAIL auto_first page got=%0d want=1", page); end
    // Manual pulse lands while the counter sits at 2.
    next_btn = 1'b1;
    tick();
    tick();
    total++;
    if (page !== 2'd1) begin bad++; $display("FAIL auto_pre_manual page got=%0d want=1", page); end
    tick();
    total++;
    if (page !== 2'd2) begin bad++; $display("FAIL auto_manual page got=%0d want=2", page); end
    next_btn = 1'b0;
    repeat (3) tick();
    total++;
    if (page !== 2'd2) begin bad++; $display("FAIL auto_restart_hold page got=%0d want=2", page); end
    tick();
    total++;
    if (page !== 2'd3) begin bad++; $display("FAIL auto_restart page got=%0d want=3", page); end
    auto_en = 1'b0;
    repeat (8) tick();
    total++;
    if (page !== 2'd3) begin bad++; $display("FAIL auto_freeze page got=%0d want=3", page); end
  endtask

  task automatic test_priority();
    press_btn();
    press_btn();
    press_btn();
    total++;
    if (page !== 2'd2) begin bad++; $display("FAIL prio_setup page got=%0d want=2", page); end
    auto_en = 1'b1;
    repeat (3) tick();
    res0 = 16'hCAFE; res1 = 16'h1357; res2 = 16'h2468; res3 = 16'hF00D;
    res_valid = 1'b1;
    tick();
    total++;
    if ({page, fresh, wrap} !== 4'b0010) begin
      bad++; $display("FAIL prio_flags got=%b want=0010", {page, fresh, wrap});
    end
    total++;
    if ({nib0, nib1, nib2, nib3} !== 16'hE78D) begin
      bad++; $display("FAIL prio_nibs got=%h want=e78d", {nib0, nib1, nib2, nib3});
    end
    auto_en = 1'b0;
    res_valid = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_async_reset();
    press_btn();
    press_btn();
    press_btn();
    total++;
    if (page !== 2'd3) begin bad++; $display("FAIL areset_setup page got=%0d want=3", page); end
    #2;
    rst = 1'b0;
    #1;
    total++;
    if ({page, blank, fresh, wrap} !== 5'b00100) begin
      bad++; $display("FAIL areset_flags got=%b want=00100", {page, blank, fresh, wrap});
    end
    total++;
    if ({nib0, nib1, nib2, nib3} !== 16'h0000) begin
      bad++; $display("FAIL areset_nibs got=%h want=0000", {nib0, nib1, nib2, nib3});
    end
    repeat (2) tick();
    rst = 1'b1;
    test_idle("post_areset");
  endtask

  initial begin
    total = 0;
    bad = 0;
    res_valid = 1'b0;
    res0 = '0; res1 = '0; res2 = '0; res3 = '0;
    next_btn = 1'b0;
    auto_en = 1'b0;
    test_reset();
    test_capture();
    test_manual();
    test_auto();
    test_priority();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
